// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the bit-serial ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic is_subtract(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// One-bit ALU cell: logic ops plus a full adder whose b input is inverted
// for subtract-style opcodes (the caller seeds carry=1 to finish two's complement).
module alu_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       r,
  output logic       cout
);

  logic b_eff;

  always_comb begin
    r     = 1'b0;
    cout  = 1'b0;
    b_eff = b ^ is_subtract(op);
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_ADD, OP_SUB, OP_SLT: begin
        r    = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (a & cin) | (b_eff & cin);
      end
      default: begin
        r    = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: one slice processes WIDTH-bit operands LSB-first, one bit
// per clock, behind valid/ready request and result ports.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for a request to latch
//   RUN   | shifting operands through the slice, one bit per clock
//   DONE  | out_valid=1, result and flags held until out_ready
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_out_q, carry_out_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic               slice_r;
  logic               slice_cout;
  logic               is_arith;
  logic               ovf_now;
  logic [WIDTH-1:0]   res_final;

  alu_slice u_slice (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .op   (op_q),
    .r    (slice_r),
    .cout (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    carry_d     = carry_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    op_d        = op_q;
    acc_d       = acc_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    is_arith    = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
    // Overflow only matters on the MSB cycle, where carry_q is the carry into the MSB.
    ovf_now     = is_arith & (carry_q ^ slice_cout);
    res_final   = {slice_r, acc_q[WIDTH-1:1]};
    if (op_q == OP_SLT) begin
      res_final = {{(WIDTH-1){1'b0}}, slice_r ^ ovf_now};
    end

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          count_d = '0;
          carry_d = is_subtract(op);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = {slice_r, acc_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = slice_cout;
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) begin
          count_d     = '0;
          result_d    = res_final;
          carry_out_d = ((op_q == OP_ADD) || (op_q == OP_SUB)) & slice_cout;
          ovf_d       = ovf_now;
          zero_d      = (res_final == '0);
          state_d     = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      op_q        <= OP_AND;
      acc_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      carry_q     <= carry_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu (WIDTH=8) with an arithmetic reference model.
module tb_serial_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out, overflow, zero;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_res;
  logic         exp_c, exp_v, exp_z;
  logic         exp_valid = 1'b0;

  serial_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: {result, carry_out, overflow, zero} from plain integer arithmetic.
  function automatic logic [W+2:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    r = '0; c = 1'b0; v = 1'b0;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: r = ~(x | y);
      3'd4: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0]; c = s[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd5: begin
        s = {1'b0, x} + {1'b0, ~y} + 1;
        r = s[W-1:0]; c = s[W];
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd6: begin
        s = {1'b0, x} + {1'b0, ~y} + 1;
        v = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
        r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      end
      default: r = '0;
    endcase
    return {r, c, v, (r == '0)};
  endfunction

  // Checks held outputs against the model every cycle a result is presented.
  always @(negedge clk) begin
    if (!reset && out_valid && exp_valid) begin
      check("result", 64'(result), 64'(exp_res));
      check("carry_out", 64'(carry_out), 64'(exp_c));
      check("overflow", 64'(overflow), 64'(exp_v));
      check("zero", 64'(zero), 64'(exp_z));
    end
  end

  // Accept one request, measure latency, optionally stall in DONE, then drain.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int stall);
    int n;
    logic [W-1:0] held;
    @(negedge clk);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    {exp_res, exp_c, exp_v, exp_z} = model(o, x, y);
    exp_valid = 1'b1;
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'(W));
    held = result;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 3'd4; a = 8'h11; b = 8'h22;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_result_held", 64'(result), 64'(held));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_valid = 1'b0;
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_in_ready", 64'(in_ready), 64'd1);
  endtask

  typedef struct {
    logic [2:0]   o;
    logic [W-1:0] x, y, r;
    logic         c, v, z;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{3'd4, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{3'd5, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{3'd5, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'd1, 8'hA0, 8'h0F, 8'hAF, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'd3, 8'hA0, 8'h0F, 8'h50, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd6, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{3'd6, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{3'd6, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd2, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd7, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'({carry_out, overflow, zero}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      check($sformatf("model_%0d", i), 64'(model(vecs[i].o, vecs[i].x, vecs[i].y)),
            64'({vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].z}));
      run_op(vecs[i].o, vecs[i].x, vecs[i].y, 0);
    end

    // Stall in DONE with a competing request present; nothing may be taken.
    run_op(3'd4, 8'h12, 8'h34, 5);
    repeat (3) begin
      @(negedge clk);
      check("no_second_accept", 64'({out_valid, in_ready}), 64'b01);
    end

    // Reset three bits into an ADD.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd4; a = 8'hFF; b = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrun_in_ready", 64'(in_ready), 64'd1);
    check("midrun_out_valid", 64'(out_valid), 64'd0);
    check("midrun_result", 64'(result), 64'd0);
    check("midrun_flags", 64'({carry_out, overflow, zero}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    check("model_after_reset", 64'(model(3'd4, 8'h03, 8'h04)), 64'({8'h07, 1'b0, 1'b0, 1'b0}));
    run_op(3'd4, 8'h03, 8'h04, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
Parametrised bit-serial ALU, successor to the team's single-bit logic cells. Uses one 1-bit ALU slice with a carry flip-flop and processes WIDTH-bit operands LSB-first, one bit per clock. Supports logic ops, add/sub and signed set-less-than, and reports flags. Sits behind a valid/ready request port and drives a valid/ready result port, so it can be dropped into the datapath in place of a wide combinational ALU where area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH), bit-counter width; derived, never overridden.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  request present.
in_ready  output  1  block can accept a request.
a  input  WIDTH  operand A, sampled on accept.
b  input  WIDTH  operand B, sampled on accept.
op  input  3  opcode, sampled on accept.
out_valid  output  1  result and flags valid.
out_ready  input  1  consumer takes the result.
result  output  WIDTH  operation result.
carry_out  output  1  final carry (ADD/SUB); 0 otherwise.
overflow  output  1  signed overflow (ADD/SUB/SLT); 0 otherwise.
zero  output  1  result == 0.

Behaviour:
- Interface: one clock clk; synchronous active-high reset named reset.
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB (a-b), 110 SLT (signed a<b), 111 reserved (result 0, all flags except zero are 0, zero=1).
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, op into shift registers, set count=0, and set carry=1 for SUB/SLT, 0 otherwise. Then go to RUN.
- RUN: in_ready=0. Each cycle the slice computes bit[count] from a_sh[0], b_sh[0] (inverted for SUB/SLT) and carry. Shift the result in at the MSB, shift the operands right, latch the new carry, count++.
- RUN exit: on the cycle processing count==WIDTH-1, latch the flags and go to DONE.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
- Flags: carry_out is the final carry. overflow is carry into the MSB XOR carry out of the MSB. SLT result = {WIDTH-1 zeros, msb_sum XOR overflow}. zero is computed on the final result.
- DONE: out_valid=1. result and flags are held stable until out_valid&&out_ready, then go to IDLE. A new request cannot be accepted in the same cycle; in_ready rises the cycle after.
- Inputs are ignored outside IDLE. in_valid while busy is neither accepted nor queued.
- Reset (in any state, including mid-RUN): next state IDLE, count=0, carry=0. result, carry_out, overflow and zero are 0, out_valid=0, in_ready=1 after the reset edge.
- Arithmetic is modulo 2^WIDTH. ADD carry-out does not widen result.

Decomposition:
- Package alu_pkg: opcode localparams (OP_AND..OP_RSVD) and the state encoding (IDLE, RUN, DONE).
- Sub-module alu_slice: combinational 1-bit cell. Inputs a, b, cin, op; outputs r, cout. Instantiated once.
- The FSM, counter and shift registers stay in serial_alu.

Test Plan:
1. WIDTH=8, ADD a=8'h7F b=8'h01 -> result 8'h80, carry_out 0, overflow 1, zero 0; out_valid rises 8 cycles after accept.
2. SUB a=8'h05 b=8'h05 -> result 8'h00, zero 1, carry_out 1, overflow 0. SUB a=8'h00 b=8'h01 -> 8'hFF, carry_out 0.
3. OR a=8'hA0 b=8'h0F -> 8'hAF; NOR same operands -> 8'h50; carry_out and overflow 0.
4. SLT a=8'h80 b=8'h01 -> 8'h01; SLT a=8'h01 b=8'h80 -> 8'h00; SLT a=8'h7F b=8'h80 -> 8'h00.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> out_valid stays 1, result is unchanged, in_ready stays 0, no second accept; after out_ready=1, in_ready=1 on the next cycle.
6. Assert reset mid-RUN at count=3 of an ADD -> after the edge: IDLE, in_ready 1, out_valid 0, result 8'h00; a following ADD 8'h03+8'h04 returns 8'h07 with correct latency.
